// File: rtl/divider_restoring_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// counter sizing helper.
package divider_restoring_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam int DIV_DEFAULT_WIDTH = 8;

  // Counter holds step indices 0..w-1.
  function automatic int div_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_restoring_seq_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor, keep the difference only when it does not borrow.
module div_step #(
  parameter int width = 8
) (
  input  logic [width-1:0] rem,
  input  logic             dvd_msb,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] rem_next,
  output logic             qbit
);

  // rem < divisor on entry, so the shifted value needs width+1 bits; the
  // remainder's MSB is kept rather than dropped so large divisors stay exact.
  logic [width:0]   rem_sh;
  logic [width+1:0] diff;
  logic             unused_diff_msb;

  always_comb begin
    rem_sh   = {rem, dvd_msb};
    diff     = {1'b0, rem_sh} - {2'b00, divisor};
    qbit     = ~diff[width+1];
    rem_next = qbit ? diff[width-1:0] : rem_sh[width-1:0];
  end

  assign unused_diff_msb = diff[width];

endmodule

// File: rtl/divider_restoring_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, IDLE/RUN/DONE
// FSM, registered q/r/dbz that hold until the next result.
module divider_restoring_seq
  import divider_restoring_seq_pkg::*;
#(
  parameter int width = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = div_cnt_w(width);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] dvd_q, dvd_d;
  logic [width-1:0] rem_q, rem_d;
  logic [width-1:0] dvs_q, dvs_d;
  logic [width-1:0] q_q, q_d;
  logic [width-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [width-1:0] step_rem;
  logic             step_qbit;
  logic             accept;
  logic             last_step;

  div_step #(.width(width)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[width-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  assign accept    = start && (state_q != S_RUN);
  assign last_step = (cnt_q == CW'(width - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start)                 state_d = (b != '0) ? S_RUN : S_DONE;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_RUN:   if (last_step) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Quotient bits fill the vacated LSBs of the dividend register.
  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    q_d   = q_q;
    r_d   = r_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvd_d = a;
      dvs_d = b;
      rem_d = '0;
      cnt_d = '0;
      if (b == '0) begin
        q_d   = '1;
        r_d   = a;
        dbz_d = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      dvd_d = {dvd_q[width-2:0], step_qbit};
      rem_d = step_rem;
      cnt_d = cnt_q + 1'b1;
      if (last_step) begin
        q_d   = {dvd_q[width-2:0], step_qbit};
        r_d   = step_rem;
        dbz_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dbz_q <= dbz_d;
    end
  end

  assign q   = q_q;
  assign r   = r_q;
  assign dbz = dbz_q;

endmodule

// File: tb/tb_divider_restoring_seq.sv
// Self-checking bench for divider_restoring_seq: vector table, multi-cycle corner
// sequences and a randomized sweep against an arithmetic reference.
module tb_divider_restoring_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic [7:0] q, r;
  logic       busy, done, dbz;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  divider_restoring_seq #(.width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero returns all ones and the dividend.
  task automatic ref_div(input logic [7:0] ta, input logic [7:0] tb, output logic [7:0] eq,
                         output logic [7:0] er, output logic edbz, output int elat);
    if (tb == 0) begin
      eq = 8'hFF; er = ta; edbz = 1'b1; elat = 1;
    end else begin
      eq = ta / tb; er = ta % tb; edbz = 1'b0; elat = 9;
    end
  endtask

  // Latency counts the start-sampling edge as edge 1.
  task automatic run_div(input logic [7:0] ta, input logic [7:0] tb, output int lat,
                         output bit busy_ok);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  initial begin
    int         lat;
    bit         bok;
    logic [7:0] eq, er;
    logic       edbz;
    int         elat;
    int         t0;
    bit         seen;

    vt[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9};
    vt[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    vt[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
    vt[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 9};
    vt[4] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 1};
    vt[5] = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0, 9};
    vt[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    vt[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9};
    vt[8] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};
    vt[9] = '{8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 9};

    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    #12;
    chk("reset_q", q, 0);
    chk("reset_r", r, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", dbz, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_div(vt[i].a, vt[i].b, lat, bok);
      chk($sformatf("vec%0d_q", i), q, vt[i].q);
      chk($sformatf("vec%0d_r", i), r, vt[i].r);
      chk($sformatf("vec%0d_dbz", i), dbz, vt[i].dbz);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy", i), bok, 1);
      repeat (2) @(posedge clk);
    end

    // Outputs hold in IDLE after a result.
    run_div(8'd200, 8'd7, lat, bok);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", q, 28);
    chk("hold_r", r, 4);
    chk("hold_done", done, 0);
    chk("hold_busy", busy, 0);

    // A start during RUN is ignored.
    @(negedge clk);
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 3) begin a = 8'd9; b = 8'd3; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("ign_lat", lat, 9);
    chk("ign_q", q, 28);
    chk("ign_r", r, 4);

    // Back-to-back: start accepted in the DONE cycle.
    repeat (2) @(posedge clk);
    run_div(8'd77, 8'd5, lat, bok);
    t0 = cyc;
    chk("b2b1_q", q, 15);
    run_div(8'd250, 8'd11, lat, bok);
    chk("b2b_gap", cyc - t0, 9);
    chk("b2b2_q", q, 22);
    chk("b2b2_r", r, 8);

    // Asynchronous reset mid-run.
    @(negedge clk);
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", q, 0);
    chk("arst_r", r, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_dbz", dbz, 0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);

    // Randomized sweep against the arithmetic reference.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      ref_div(ra, rb, eq, er, edbz, elat);
      run_div(ra, rb, lat, bok);
      chk($sformatf("rnd a=%0d b=%0d q", ra, rb), q, eq);
      chk($sformatf("rnd a=%0d b=%0d r", ra, rb), r, er);
      chk($sformatf("rnd a=%0d b=%0d dbz", ra, rb), dbz, edbz);
      chk($sformatf("rnd a=%0d b=%0d lat", ra, rb), lat, elat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
